// File: rtl/npu_dot_seq_pkg.sv
// Shared types and constants for the NPU dot-product sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package npu_dot_seq_pkg;

    localparam int NPU_LANES = 16;              // INT8 lanes per chunk
    localparam int NPU_DP_W  = NPU_LANES * 8;   // one buffer word = one chunk
    localparam int NPU_ACC_W = 32;              // accumulator / result width

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_RESULT = 2'd3
    } state_e;

endpackage

// File: rtl/npu_dot_seq.sv
// Sequencer: streams len 128-bit chunks from weight/input buffers into the 16-MAC dot unit and sums the results.
// Latency: accept at T -> reads T+1..T+len -> res_valid at T+len+3 (len==0: res_valid at T+1); 1 chunk/cycle.
// Backpressure: cmd_ready only in IDLE (no queueing); result held on res_valid until res_ready.
//
// Ports: cmd_* command in (len in chunks, word base addresses), abort cancels RUN/DRAIN with no result;
//        w_rd_*/x_rd_* buffer read ports (data 1 cycle after strobe); dp_* dot-unit interface
//        (dp_result registered, 1 cycle after dp_enable); res_* valid/ready final sum; busy = not IDLE.
// Option: define NPU_SEQ_RELU_EN to clamp negative sums to 0 when the result is captured.
module npu_dot_seq
    import npu_dot_seq_pkg::*;
#(
    parameter int LEN_W  = 8,
    parameter int ADDR_W = 12,
    parameter int ACC_W  = NPU_ACC_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [ADDR_W-1:0]   cmd_w_base,
    input  logic [ADDR_W-1:0]   cmd_x_base,
    input  logic                abort,
    output logic                w_rd_en,
    output logic [ADDR_W-1:0]   w_rd_addr,
    input  logic [NPU_DP_W-1:0] w_rd_data,
    output logic                x_rd_en,
    output logic [ADDR_W-1:0]   x_rd_addr,
    input  logic [NPU_DP_W-1:0] x_rd_data,
    output logic                dp_enable,
    output logic [NPU_DP_W-1:0] dp_weight,
    output logic [NPU_DP_W-1:0] dp_input,
    input  logic [31:0]         dp_result,
    input  logic                dp_valid,
    output logic                res_valid,
    output logic [ACC_W-1:0]    res_data,
    input  logic                res_ready,
    output logic                busy
);

    state_e                   state_q, state_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic [ADDR_W-1:0]        w_base_q, w_base_d;
    logic [ADDR_W-1:0]        x_base_q, x_base_d;
    logic [LEN_W-1:0]         issue_cnt_q, issue_cnt_d;
    logic [LEN_W-1:0]         acc_cnt_q, acc_cnt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]         res_q, res_d;
    logic                     pipe_vld_q;

    logic                     cmd_fire;
    logic                     rd_en;
    logic                     acc_fire;
    logic                     last_issue;
    logic [LEN_W-1:0]         acc_cnt_inc;

    assign cmd_fire    = (state_q == ST_IDLE) && cmd_valid;
    // Results arriving outside RUN/DRAIN belong to an aborted command and are dropped.
    assign acc_fire    = dp_valid && !abort && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    assign last_issue  = (issue_cnt_q == (len_q - LEN_W'(1)));
    assign acc_cnt_inc = acc_cnt_q + LEN_W'(1);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cmd_valid) state_d = (cmd_len == '0) ? ST_RESULT : ST_RUN;
            ST_RUN:    if (abort) state_d = ST_IDLE;
                       else if (last_issue) state_d = ST_DRAIN;
            // Compare against the post-increment count so RESULT is entered right after the
            // final chunk lands, not one cycle later.
            ST_DRAIN:  if (abort) state_d = ST_IDLE;
                       else if (acc_fire && (acc_cnt_inc == len_q)) state_d = ST_RESULT;
            ST_RESULT: if (res_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        rd_en     = (state_q == ST_RUN) && !abort;
        res_valid = (state_q == ST_RESULT);
    end

    assign w_rd_en   = rd_en;
    assign x_rd_en   = rd_en;
    assign w_rd_addr = w_base_q + ADDR_W'(issue_cnt_q);   // wraps modulo 2^ADDR_W
    assign x_rd_addr = x_base_q + ADDR_W'(issue_cnt_q);
    assign dp_enable = pipe_vld_q;
    assign dp_weight = w_rd_data;
    assign dp_input  = x_rd_data;
    assign res_data  = res_q;

    // ---------------- datapath next-state ----------------
    always_comb begin
        len_d       = len_q;
        w_base_d    = w_base_q;
        x_base_d    = x_base_q;
        issue_cnt_d = issue_cnt_q;
        acc_cnt_d   = acc_cnt_q;
        acc_d       = acc_q;
        res_d       = res_q;

        if (cmd_fire) begin
            len_d       = cmd_len;
            w_base_d    = cmd_w_base;
            x_base_d    = cmd_x_base;
            issue_cnt_d = '0;
            acc_cnt_d   = '0;
            acc_d       = '0;
            res_d       = '0;   // zero-length command reports an empty sum
        end

        if (rd_en) begin
            issue_cnt_d = issue_cnt_q + LEN_W'(1);
        end

        if (acc_fire) begin
            acc_d     = acc_q + ACC_W'($signed(dp_result));
            acc_cnt_d = acc_cnt_inc;
        end

        // Capture once on entry to RESULT so res_data is frozen while it waits for res_ready.
        if ((state_q == ST_DRAIN) && (state_d == ST_RESULT)) begin
`ifdef NPU_SEQ_RELU_EN
            res_d = acc_d[ACC_W-1] ? '0 : acc_d;
`else
            res_d = acc_d;
`endif
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q       <= '0;
            w_base_q    <= '0;
            x_base_q    <= '0;
            issue_cnt_q <= '0;
            acc_cnt_q   <= '0;
            acc_q       <= '0;
            res_q       <= '0;
            pipe_vld_q  <= 1'b0;
        end else begin
            len_q       <= len_d;
            w_base_q    <= w_base_d;
            x_base_q    <= x_base_d;
            issue_cnt_q <= issue_cnt_d;
            acc_cnt_q   <= acc_cnt_d;
            acc_q       <= acc_d;
            res_q       <= res_d;
            pipe_vld_q  <= rd_en;   // read data, and so dot-unit operands, arrive one cycle later
        end
    end

endmodule

// File: tb/tb_npu_dot_seq.sv
module tb_npu_dot_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [7:0]   cmd_len;
    logic [11:0]  cmd_w_base;
    logic [11:0]  cmd_x_base;
    logic         abort;
    logic         w_rd_en;
    logic [11:0]  w_rd_addr;
    logic [127:0] w_rd_data = '0;
    logic         x_rd_en;
    logic [11:0]  x_rd_addr;
    logic [127:0] x_rd_data = '0;
    logic         dp_enable;
    logic [127:0] dp_weight;
    logic [127:0] dp_input;
    logic [31:0]  dp_result = '0;
    logic         dp_valid = 1'b0;
    logic         res_valid;
    logic [31:0]  res_data;
    logic         res_ready;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] wmem [4096];
    logic [127:0] xmem [4096];

    always #5 clk = ~clk;

    npu_dot_seq dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .cmd_w_base (cmd_w_base),
        .cmd_x_base (cmd_x_base),
        .abort      (abort),
        .w_rd_en    (w_rd_en),
        .w_rd_addr  (w_rd_addr),
        .w_rd_data  (w_rd_data),
        .x_rd_en    (x_rd_en),
        .x_rd_addr  (x_rd_addr),
        .x_rd_data  (x_rd_data),
        .dp_enable  (dp_enable),
        .dp_weight  (dp_weight),
        .dp_input   (dp_input),
        .dp_result  (dp_result),
        .dp_valid   (dp_valid),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .busy       (busy)
    );

    // Signed INT8 dot product of two 16-byte words.
    function automatic int dot16(input logic [127:0] a, input logic [127:0] b);
        int s;
        logic signed [7:0] ea, eb;
        s = 0;
        for (int i = 0; i < 16; i++) begin
            ea = a[8*i +: 8];
            eb = b[8*i +: 8];
            s += int'(ea) * int'(eb);
        end
        return s;
    endfunction

    // Environment: buffers with 1-cycle read latency and a registered dot-product unit.
    always @(posedge clk) begin
        w_rd_data <= w_rd_en ? wmem[w_rd_addr] : '0;
        x_rd_data <= x_rd_en ? xmem[x_rd_addr] : '0;
        dp_valid  <= dp_enable;
        dp_result <= dot16(dp_weight, dp_input);
    end

    // Reference: whole-vector dot product straight from buffer contents.
    function automatic logic [31:0] ref_sum(input int len, input logic [11:0] wb, input logic [11:0] xb);
        int s;
        s = 0;
        for (int c = 0; c < len; c++)
            s += dot16(wmem[12'(int'(wb) + c)], xmem[12'(int'(xb) + c)]);
`ifdef NPU_SEQ_RELU_EN
        if (s < 0) s = 0;
`endif
        return 32'(s);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rand(input int len, input logic [11:0] wb, input logic [11:0] xb);
        for (int c = 0; c < len; c++) begin
            wmem[12'(int'(wb) + c)] = {$urandom, $urandom, $urandom, $urandom};
            xmem[12'(int'(xb) + c)] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // Issue one command and check every cycle up to result hand-off (or abort).
    task automatic run_cmd(input int len, input logic [11:0] wb, input logic [11:0] xb,
                           input int hold, input int abort_at);
        logic [31:0] exp;
        logic [11:0] ea;
        int lat;
        bit exp_rd;
        exp = ref_sum(len, wb, xb);
        lat = (len == 0) ? 1 : len + 3;

        chk("cmd_ready_before", cmd_ready, 1'b1);
        cmd_valid  = 1'b1;
        cmd_len    = 8'(len);
        cmd_w_base = wb;
        cmd_x_base = xb;
        step();
        cmd_valid  = 1'b0;
        cmd_len    = 8'($urandom);
        cmd_w_base = 12'($urandom);
        cmd_x_base = 12'($urandom);

        for (int k = 1; k <= lat; k++) begin
            if (k == abort_at) abort = 1'b1;
            #1;
            exp_rd = (k <= len) && (abort_at == 0 || k < abort_at);
            chk("w_rd_en", w_rd_en, exp_rd);
            chk("x_rd_en", x_rd_en, exp_rd);
            if (exp_rd) begin
                ea = 12'(int'(wb) + k - 1);
                chk("w_rd_addr", w_rd_addr, ea);
                ea = 12'(int'(xb) + k - 1);
                chk("x_rd_addr", x_rd_addr, ea);
            end
            chk("dp_enable", dp_enable, (k >= 2) && (k <= len + 1) && (abort_at == 0 || k <= abort_at));
            chk("res_valid", res_valid, (k == lat) && (abort_at == 0));
            chk("busy", busy, 1'b1);
            chk("cmd_ready_busy", cmd_ready, 1'b0);
            if (k == abort_at) begin
                step();
                abort = 1'b0;
                chk("abort_cmd_ready", cmd_ready, 1'b1);
                chk("abort_busy", busy, 1'b0);
                chk("abort_res_valid", res_valid, 1'b0);
                chk("abort_rd_en", w_rd_en, 1'b0);
                return;
            end
            if (k == lat) chk("res_data", res_data, exp);
            else step();
        end

        // Stall the consumer; offer a command that must be ignored.
        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'b1;
            cmd_len   = 8'($urandom_range(1, 255));
            step();
            chk("hold_res_valid", res_valid, 1'b1);
            chk("hold_res_data", res_data, exp);
            chk("hold_cmd_ready", cmd_ready, 1'b0);
            chk("hold_rd_en", w_rd_en, 1'b0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("done_res_valid", res_valid, 1'b0);
        chk("done_cmd_ready", cmd_ready, 1'b1);
        chk("done_busy", busy, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_len    = '0;
        cmd_w_base = '0;
        cmd_x_base = '0;
        abort      = 1'b0;
        res_ready  = 1'b0;
        for (int a = 0; a < 4096; a++) begin
            wmem[a] = '0;
            xmem[a] = '0;
        end
        repeat (3) step();

        // Reset state
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_w_rd_en", w_rd_en, 1'b0);
        chk("rst_x_rd_en", x_rd_en, 1'b0);
        chk("rst_w_rd_addr", w_rd_addr, 12'h0);
        chk("rst_x_rd_addr", x_rd_addr, 12'h0);
        chk("rst_dp_enable", dp_enable, 1'b0);
        chk("rst_dp_weight", dp_weight[63:0], 64'h0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_data", res_data, 32'h0);
        rst = 1'b0;
        step();

        // 1: single chunk, all-ones x all-twos = 32
        wmem[12'h010] = {16{8'h01}};
        xmem[12'h020] = {16{8'h02}};
        run_cmd(1, 12'h010, 12'h020, 0, 0);

        // 2: chunk sums 100,-50,7,-57 cancel to 0
        for (int c = 0; c < 4; c++) wmem[12'h100 + 12'(c)] = 128'h1;
        xmem[12'h200] = 128'd100;
        xmem[12'h201] = 128'hCE;
        xmem[12'h202] = 128'd7;
        xmem[12'h203] = 128'hC7;
        run_cmd(4, 12'h100, 12'h200, 0, 0);

        // 3: zero-length command
        run_cmd(0, 12'h123, 12'h456, 0, 0);

        // 4: weight address wraps
        fill_rand(3, 12'hFFF, 12'h7FE);
        run_cmd(3, 12'hFFF, 12'h7FE, 0, 0);

        // 5: abort mid-run, then a fresh command immediately (stale dp_valid in flight)
        fill_rand(8, 12'h300, 12'h400);
        run_cmd(8, 12'h300, 12'h400, 0, 4);
        fill_rand(1, 12'h500, 12'h600);
        run_cmd(1, 12'h500, 12'h600, 0, 0);

        // 6: consumer stalls 10 cycles on a negative sum (-5)
        wmem[12'h050] = 128'h1;
        xmem[12'h060] = 128'hFB;
        run_cmd(1, 12'h050, 12'h060, 10, 0);

        // Reset in the middle of a command
        fill_rand(10, 12'h700, 12'h800);
        cmd_valid = 1'b1; cmd_len = 8'd10; cmd_w_base = 12'h700; cmd_x_base = 12'h800;
        step();
        cmd_valid = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_cmd_ready", cmd_ready, 1'b1);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_rd_en", w_rd_en, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mrst_res_valid", res_valid, 1'b0);
        end

        // Random commands
        for (int n = 0; n < 8; n++) begin
            int len;
            logic [11:0] wb, xb;
            len = $urandom_range(1, 40);
            wb  = 12'($urandom);
            xb  = 12'($urandom);
            fill_rand(len, wb, xb);
            run_cmd(len, wb, xb, $urandom_range(0, 3), 0);
        end

        // Maximum length with maximum-magnitude products, then random
        for (int c = 0; c < 255; c++) begin
            wmem[12'hE00 + 12'(c)] = {16{8'h80}};
            xmem[12'h900 + 12'(c)] = {16{8'h80}};
        end
        run_cmd(255, 12'hE00, 12'h900, 0, 0);
        fill_rand(255, 12'hF80, 12'h080);
        run_cmd(255, 12'hF80, 12'h080, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
